// File: rtl/vconvg16.sv
// vconvg16: vertical 5-tap Gaussian (3,14,94,14,3)/128 over a row-major
// 16-bit stream. Four line buffers hold the previous rows; rows outside
// the frame are masked to zero and the last two rows are flushed
// internally. Optional macro VCONV_ROUND_EN selects round-half-up instead
// of truncation.
module vconvg16 #(
  parameter logic [15:0] IM_LEN  = 16'd520,
  parameter logic [15:0] IM_ROWS = 16'd520
) (
  input  logic        clk,
  input  logic        vres,
  input  logic [15:0] vin,
  input  logic        vin_valid,
  output logic        vin_ready,
  input  logic        vclrbuffer,
  output logic [15:0] vout,
  output logic        vout_valid,
  output logic        vframe_done
);

  localparam int unsigned PW    = 16;
  localparam int unsigned SW    = 23;
  localparam int unsigned DEPTH = 32'(IM_LEN);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] COL_LAST = AW'(IM_LEN - 16'd1);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   col_q, col_d;
  logic [15:0]     k_q, k_d;

  logic [PW-1:0]   lb1_q [DEPTH];
  logic [PW-1:0]   lb2_q [DEPTH];
  logic [PW-1:0]   lb3_q [DEPTH];
  logic [PW-1:0]   lb4_q [DEPTH];

  logic            beat;
  logic [PW-1:0]   cur_px;
  logic [PW-1:0]   t0, t1, t2, t3, t4;
  logic [PW:0]     sum04, sum13;

  logic            s1_valid_q, s1_valid_d;
  logic            s1_last_q, s1_last_d;
  logic [PW-1:0]   s1_t2_q, s1_t2_d;
  logic [SW-1:0]   s1_part_q, s1_part_d;

  logic [SW-1:0]   w94, sum;
  logic [PW-1:0]   vout_q, vout_d;
  logic            vout_valid_q, vout_valid_d;
  logic            vframe_done_q, vframe_done_d;

  // Accept handshake and the per-cycle beat (input pixel or flush zero)
  assign vin_ready = (state_q == RUN) & ~vclrbuffer & ~vres;
  assign beat      = (vin_ready & vin_valid) |
                     ((state_q == FLUSH) & ~vclrbuffer & ~vres);
  assign cur_px    = (state_q == RUN) ? vin : '0;

  // Tap selection with zero masking for rows outside the frame
  always_comb begin
    t0    = (k_q >= 16'd4)    ? lb4_q[col_q] : '0;
    t1    = (k_q >= 16'd3)    ? lb3_q[col_q] : '0;
    t2    = lb2_q[col_q];
    t3    = (k_q <= IM_ROWS)  ? lb1_q[col_q] : '0;
    t4    = (k_q <  IM_ROWS)  ? cur_px       : '0;
    sum04 = {1'b0, t0} + {1'b0, t4};
    sum13 = {1'b0, t1} + {1'b0, t3};
  end

  // Next-state logic for the RUN/FLUSH sequencer and position counters
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    k_d     = k_q;
    if (vclrbuffer) begin
      state_d = RUN;
      col_d   = '0;
      k_d     = '0;
    end else if (beat) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if ((state_q == RUN) && (k_q == IM_ROWS - 16'd1)) begin
          state_d = FLUSH;
          k_d     = k_q + 16'd1;
        end else if ((state_q == FLUSH) && (k_q == IM_ROWS + 16'd1)) begin
          state_d = RUN;
          k_d     = '0;
        end else begin
          k_d = k_q + 16'd1;
        end
      end else begin
        col_d = col_q + AW'(1);
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge vres) begin
    if (vres) begin
      state_q <= RUN;
      col_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      k_q     <= k_d;
    end
  end

  // Line buffers shift down one row at the current column on every beat
  always_ff @(posedge clk) begin
    if (beat) begin
      lb4_q[col_q] <= lb3_q[col_q];
      lb3_q[col_q] <= lb2_q[col_q];
      lb2_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= cur_px;
    end
  end

  // Pipeline next-state: stage 1 partial sums, stage 2 full sum
  always_comb begin
    s1_valid_d = beat & (k_q >= 16'd2);
    s1_last_d  = beat & (k_q == IM_ROWS + 16'd1) & (col_q == COL_LAST);
    s1_t2_d    = t2;
    s1_part_d  = SW'({sum04, 1'b0}) + SW'(sum04) +
                 SW'({sum13, 3'b000}) + SW'({sum13, 2'b00}) + SW'({sum13, 1'b0});

    w94 = SW'({s1_t2_q, 6'b0}) + SW'({s1_t2_q, 4'b0}) + SW'({s1_t2_q, 3'b0}) +
          SW'({s1_t2_q, 2'b0}) + SW'({s1_t2_q, 1'b0});
    sum = s1_part_q + w94;
`ifdef VCONV_ROUND_EN
    sum = sum + SW'(64);
`endif
    vout_d        = s1_valid_q ? PW'(sum >> 7) : vout_q;
    vout_valid_d  = s1_valid_q & ~vclrbuffer;
    vframe_done_d = s1_last_q & ~vclrbuffer;
  end

  // Pipeline registers; a frame restart squashes anything in flight
  always_ff @(posedge clk or posedge vres) begin
    if (vres) begin
      s1_valid_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_t2_q       <= '0;
      s1_part_q     <= '0;
      vout_q        <= '0;
      vout_valid_q  <= 1'b0;
      vframe_done_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_last_q     <= s1_last_d;
      s1_t2_q       <= s1_t2_d;
      s1_part_q     <= s1_part_d;
      vout_q        <= vout_d;
      vout_valid_q  <= vout_valid_d;
      vframe_done_q <= vframe_done_d;
    end
  end

  assign vout        = vout_q;
  assign vout_valid  = vout_valid_q;
  assign vframe_done = vframe_done_q;

endmodule
